// File: rtl/div_pkg.sv
// div_pkg: shared widths and FSM encoding for the sequential divider
package div_pkg;
  localparam int DW_DEF = 7;
  localparam int VW_DEF = 3;
  localparam int CW_DEF = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bus of the divider
interface seq_divider_if import div_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, dbz);
  modport slave  (input start, dividend, divisor, output busy, done, quotient, remainder, dbz);
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step import div_pkg::*; #(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   pr,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_next,
  output logic          qbit
);
  logic [VW:0] t;
  assign t = {pr[VW-1:0], din};
  // a set top bit of pr can only mean pr already reached the divisor, so it forces a subtract
  assign qbit = pr[VW] || (t >= {1'b0, divisor});
  assign pr_next = qbit ? t - {1'b0, divisor} : t;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock
module seq_divider import div_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF,
  parameter int CW = CW_DEF
) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave bus
);
  state_t        state, state_n;
  logic [DW-1:0] dsr, qsr, quotient;
  logic [VW-1:0] dvs, remainder;
  logic [VW:0]   pr, pr_n;
  logic [CW-1:0] cnt;
  logic          qb, done, dbz, last;
  assign last = cnt == CW'(1);
  div_step #(.VW(VW)) u_step (
    .pr(pr),
    .din(dsr[DW-1]),
    .divisor(dvs),
    .pr_next(pr_n),
    .qbit(qb)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state; ZERO and the unused encoding both return to IDLE
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = bus.start ? (bus.divisor == '0 ? ZERO : RUN) : IDLE;
      RUN:     state_n = last ? IDLE : RUN;
      default: state_n = IDLE;
    endcase
  end
  // datapath: operand capture, restoring iterations and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dsr       <= '0;
      dvs       <= '0;
      pr        <= '0;
      qsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          dsr <= bus.dividend;
          dvs <= bus.divisor;
          pr  <= '0;
          qsr <= '0;
          cnt <= CW'(DW);
        end
        RUN: begin
          dsr <= {dsr[DW-2:0], 1'b0};
          pr  <= pr_n;
          qsr <= {qsr[DW-2:0], qb};
          cnt <= cnt - CW'(1);
          if (last) begin
            quotient  <= {qsr[DW-2:0], qb};
            remainder <= pr_n[VW-1:0];
            dbz       <= 1'b0;
            done      <= 1'b1;
          end
        end
        ZERO: begin
          quotient  <= '1;
          remainder <= '0;
          dbz       <= 1'b1;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign bus.busy      = (state == RUN) || (state == ZERO);
  assign bus.done      = done;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.dbz       = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for the sequential divider
module tb_seq_divider;
  typedef struct packed {
    logic [6:0] q;
    logic [2:0] r;
    logic       z;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  seq_divider_if #(.DW(7), .VW(3)) bus ();
  seq_divider dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // caller sits at a negedge; drives one accept edge and records the expected result
  task automatic go(input int dd, input int dv);
    exp_t e;
    bus.start = 1'b1;
    bus.dividend = 7'(dd);
    bus.divisor = 3'(dv);
    e.q = dv == 0 ? 7'h7F : 7'(dd / dv);
    e.r = dv == 0 ? 3'd0 : 3'(dd % dv);
    e.z = dv == 0;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  // waits (bounded) for done, returning the number of negedges spent
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz} !== 12'd0) begin
      failures++;
      $display("FAIL reset got busy=%b done=%b q=%0d r=%0d dbz=%b want all zero", bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
  endtask
  task automatic test_basic();
    int n;
    exp_t e;
    go(100, 7);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %b want 1", bus.busy);
    end
    wait_done(n);
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL basic_latency got %0d want 7", n);
    end
    e = sb.pop_front();
    checks++;
    if (bus.quotient !== e.q || bus.remainder !== e.r || bus.dbz !== e.z || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got q=%0d r=%0d z=%b busy=%b want q=%0d r=%0d z=%b busy=0", bus.quotient, bus.remainder, bus.dbz, bus.busy, e.q, e.r, e.z);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 7'd14 || bus.remainder !== 3'd2) begin
      failures++;
      $display("FAIL basic_hold got done=%b q=%0d r=%0d want done=0 q=14 r=2", bus.done, bus.quotient, bus.remainder);
    end
  endtask
  task automatic test_corners();
    int n;
    exp_t e;
    int dds[3] = '{127, 5, 0};
    int dvs[3] = '{1, 7, 3};
    for (int i = 0; i < 3; i++) begin
      go(dds[i], dvs[i]);
      wait_done(n);
      e = sb.pop_front();
      checks++;
      if (n !== 7 || bus.quotient !== e.q || bus.remainder !== e.r || bus.dbz !== e.z) begin
        failures++;
        $display("FAIL corner_%0d_%0d got n=%0d q=%0d r=%0d z=%b want n=7 q=%0d r=%0d z=%b", dds[i], dvs[i], n, bus.quotient, bus.remainder, bus.dbz, e.q, e.r, e.z);
      end
    end
  endtask
  task automatic test_zero();
    int n;
    exp_t e;
    go(42, 0);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== 1 || bus.quotient !== e.q || bus.remainder !== e.r || bus.dbz !== e.z || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL dbz got n=%0d q=%h r=%0d z=%b busy=%b want n=1 q=%h r=%0d z=%b busy=0", n, bus.quotient, bus.remainder, bus.dbz, bus.busy, e.q, e.r, e.z);
    end
    @(negedge clk);
    go(10, 3);
    checks++;
    if (bus.dbz !== 1'b1) begin
      failures++;
      $display("FAIL dbz_hold got %b want 1", bus.dbz);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== 7 || bus.quotient !== e.q || bus.remainder !== e.r || bus.dbz !== 1'b0) begin
      failures++;
      $display("FAIL dbz_clear got n=%0d q=%0d r=%0d z=%b want n=7 q=%0d r=%0d z=0", n, bus.quotient, bus.remainder, bus.dbz, e.q, e.r);
    end
    @(negedge clk);
  endtask
  task automatic test_ignore();
    int n;
    int pulses;
    exp_t e;
    go(100, 7);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 7'd9;
    bus.divisor = 3'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== 5 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      failures++;
      $display("FAIL ignore_result got n=%0d q=%0d r=%0d want n=5 q=%0d r=%0d", n, bus.quotient, bus.remainder, e.q, e.r);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || bus.quotient !== 7'd14) begin
      failures++;
      $display("FAIL ignore_extra got activity=%0d q=%0d want activity=0 q=14", pulses, bus.quotient);
    end
  endtask
  task automatic test_abort();
    int n;
    int pulses;
    exp_t e;
    go(100, 7);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz} !== 12'd0) begin
      failures++;
      $display("FAIL abort_state got busy=%b done=%b q=%0d r=%0d dbz=%b want all zero", bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abort_done got %0d pulses want 0", pulses);
    end
    go(60, 5);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== 7 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      failures++;
      $display("FAIL abort_fresh got n=%0d q=%0d r=%0d want n=7 q=%0d r=%0d", n, bus.quotient, bus.remainder, e.q, e.r);
    end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    int n;
    exp_t e;
    go(100, 7);
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== 7 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      failures++;
      $display("FAIL b2b_first got n=%0d q=%0d r=%0d want n=7 q=%0d r=%0d", n, bus.quotient, bus.remainder, e.q, e.r);
    end
    go(99, 4);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 7'd14 || bus.remainder !== 3'd2) begin
      failures++;
      $display("FAIL b2b_hold got busy=%b done=%b q=%0d r=%0d want busy=1 done=0 q=14 r=2", bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== 7 || bus.quotient !== e.q || bus.remainder !== e.r || bus.dbz !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got n=%0d q=%0d r=%0d z=%b want n=7 q=%0d r=%0d z=0", n, bus.quotient, bus.remainder, bus.dbz, e.q, e.r);
    end
    @(negedge clk);
  endtask
  task automatic test_sweep();
    int n;
    exp_t e;
    for (int dd = 0; dd < 128; dd++)
      for (int dv = 1; dv < 8; dv++) begin
        go(dd, dv);
        wait_done(n);
        e = sb.pop_front();
        checks++;
        if (n !== 7 || bus.quotient !== e.q || bus.remainder !== e.r || bus.dbz !== e.z) begin
          failures++;
          $display("FAIL sweep_%0d_%0d got n=%0d q=%0d r=%0d z=%b want n=7 q=%0d r=%0d z=%b", dd, dv, n, bus.quotient, bus.remainder, bus.dbz, e.q, e.r, e.z);
        end
        checks++;
        if ((int'(bus.quotient) * dv + int'(bus.remainder)) !== dd || int'(bus.remainder) >= dv) begin
          failures++;
          $display("FAIL sweep_inv_%0d_%0d got q=%0d r=%0d want q*d+r=%0d with r<%0d", dd, dv, bus.quotient, bus.remainder, dd, dv);
        end
      end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_zero();
    test_ignore();
    test_abort();
    test_back_to_back();
    test_sweep();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
